// File: rtl/painel_chamadas.sv
// Floor-call panel: latches button presses, picks the next floor with a SCAN policy
// and dispatches it as a one-hot request, with a sticky timeout fault.
module painel_chamadas #(
    parameter int TIMEOUT = 31
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] botao,
    input  logic       busy,
    input  logic       door_open,
    input  logic [2:0] andar_atual,
    output logic [4:0] req,
    output logic [4:0] pendentes,
    output logic [2:0] alvo,
    output logic       atendendo,
    output logic       dir,
    output logic       falha,
    output logic [7:0] atendidos
);
    typedef enum logic {IDLE = 1'b0, SERVING = 1'b1} state_t;

    state_t     state, state_nxt;
    logic [4:0] botao_q, borda, clr_mask;
    logic [4:0] cnt;
    logic       dispatch, arrive, tmo;
    logic [2:0] sel, lo_ge, hi_le, lo_all, hi_all;
    logic       sel_dir, any_ge, any_le;

    assign borda    = botao & ~botao_q;
    assign dispatch = (state == IDLE) && (pendentes != 5'd0) && !busy && !door_open && !falha;
    assign arrive   = (state == SERVING) && door_open && (andar_atual == alvo);
    assign tmo      = (state == SERVING) && !arrive && (cnt == 5'(TIMEOUT));
    // Clearing the served/abandoned floor overrides a same-edge press of that floor.
    assign clr_mask = (arrive || tmo) ? (5'd1 << alvo) : 5'd0;

    // SCAN selection: later loop iterations override earlier ones, giving lowest/highest.
    always_comb begin
        lo_ge  = '0;
        hi_le  = '0;
        lo_all = '0;
        hi_all = '0;
        any_ge = 1'b0;
        any_le = 1'b0;
        for (int i = 4; i >= 0; i--) begin
            if (pendentes[i]) begin
                lo_all = 3'(i);
                if (3'(i) >= andar_atual) begin
                    any_ge = 1'b1;
                    lo_ge  = 3'(i);
                end
            end
        end
        for (int i = 0; i < 5; i++) begin
            if (pendentes[i]) begin
                hi_all = 3'(i);
                if (3'(i) <= andar_atual) begin
                    any_le = 1'b1;
                    hi_le  = 3'(i);
                end
            end
        end
        if (!dir) begin
            sel     = any_ge ? lo_ge : hi_all;
            sel_dir = !any_ge;
        end else begin
            sel     = any_le ? hi_le : lo_all;
            sel_dir = any_le;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (dispatch) state_nxt = SERVING;
            SERVING: if (arrive || tmo) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        atendendo = (state == SERVING);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            botao_q   <= '0;
            pendentes <= '0;
            req       <= '0;
            alvo      <= '0;
            dir       <= 1'b0;
            falha     <= 1'b0;
            atendidos <= '0;
            cnt       <= '0;
        end else begin
            botao_q   <= botao;
            pendentes <= (pendentes | borda) & ~clr_mask;
            if (dispatch) begin
                req  <= 5'd1 << sel;
                alvo <= sel;
                dir  <= sel_dir;
                cnt  <= '0;
            end else begin
                if (arrive || tmo) req <= '0;
                if (state == SERVING) cnt <= cnt + 5'd1;
            end
            if (tmo) falha <= 1'b1;
            if (arrive && atendidos != 8'hFF) atendidos <= atendidos + 8'd1;
        end
    end
endmodule

// File: tb/tb_painel_chamadas.sv
// Bench for painel_chamadas: directed table, hand-written corner sequences,
// and a randomized run against a floor-list reference model.
module tb_painel_chamadas;
    localparam int TIMEOUT = 31;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [4:0] botao = '0;
    logic       busy = 1'b0;
    logic       door_open = 1'b0;
    logic [2:0] andar_atual = '0;
    logic [4:0] req, pendentes;
    logic [2:0] alvo;
    logic       atendendo, dir, falha;
    logic [7:0] atendidos;

    int n_cmp = 0;
    int n_bad = 0;

    painel_chamadas #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .botao(botao), .busy(busy), .door_open(door_open),
        .andar_atual(andar_atual), .req(req), .pendentes(pendentes), .alvo(alvo),
        .atendendo(atendendo), .dir(dir), .falha(falha), .atendidos(atendidos)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] botao;
        logic       busy;
        logic       door;
        logic [2:0] andar;
        logic [4:0] e_req;
        logic [4:0] e_pend;
        logic       e_atd;
        logic       e_dir;
        logic [7:0] e_cnt;
    } vec_t;

    vec_t tbl[10];

    // reference model state
    logic [4:0] m_pend, m_req, m_prev;
    int         m_alvo, m_atend, m_cyc, m_tdisp;
    bit         m_dir, m_falha, m_serv;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic [4:0] b, input logic bz, input logic d, input logic [2:0] a,
                                input logic [4:0] er, input logic [4:0] ep, input logic ea,
                                input logic ed, input logic [7:0] ec);
        vec_t v;
        v.botao = b; v.busy = bz; v.door = d; v.andar = a;
        v.e_req = er; v.e_pend = ep; v.e_atd = ea; v.e_dir = ed; v.e_cnt = ec;
        return v;
    endfunction

    task automatic edge_();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        botao = '0; busy = 1'b0; door_open = 1'b0; andar_atual = '0;
        reset = 1'b1;
        edge_();
        reset = 1'b0;
    endtask

    task automatic model_reset();
        m_pend = '0; m_req = '0; m_prev = '0; m_alvo = 0; m_atend = 0;
        m_dir = 0; m_falha = 0; m_serv = 0; m_cyc = 0; m_tdisp = 0;
    endtask

    // SCAN choice written over the list of pending floors
    task automatic pick(input logic [4:0] p, input int cur, input bit d, output int fl, output bit nd);
        int lo_ge = -1, hi_le = -1, lo = -1, hi = -1;
        for (int f = 0; f < 5; f++) begin
            if (p[f]) begin
                if (lo < 0) lo = f;
                hi = f;
                if (f >= cur && lo_ge < 0) lo_ge = f;
                if (f <= cur) hi_le = f;
            end
        end
        if (!d) begin
            if (lo_ge >= 0) begin fl = lo_ge; nd = 0; end
            else begin fl = hi; nd = 1; end
        end else begin
            if (hi_le >= 0) begin fl = hi_le; nd = 1; end
            else begin fl = lo; nd = 0; end
        end
    endtask

    // advance the model by one clock edge using the currently driven inputs
    task automatic model_step();
        logic [4:0] rise, np;
        bit arr, tmo, disp, nd;
        int fl;
        m_cyc++;
        rise = botao & ~m_prev;
        arr  = m_serv && door_open && (int'(andar_atual) == m_alvo);
        tmo  = m_serv && !arr && (m_cyc - m_tdisp == TIMEOUT + 1);
        disp = !m_serv && (m_pend != 0) && !busy && !door_open && !m_falha;
        np = m_pend | rise;
        if (disp) begin
            pick(m_pend, int'(andar_atual), m_dir, fl, nd);
            m_alvo = fl; m_dir = nd; m_req = 5'd1 << fl;
            m_serv = 1; m_tdisp = m_cyc;
        end else if (arr || tmo) begin
            np[m_alvo] = 1'b0;
            m_req = '0; m_serv = 0;
            if (arr && m_atend < 255) m_atend++;
            if (tmo) m_falha = 1;
        end
        m_pend = np;
        m_prev = botao;
    endtask

    task automatic chk_model(input string nm);
        chk({nm, ".req"}, 8'(req), 8'(m_req));
        chk({nm, ".pend"}, 8'(pendentes), 8'(m_pend));
        chk({nm, ".alvo"}, 8'(alvo), 8'(m_alvo));
        chk({nm, ".atd"}, 8'(atendendo), 8'(m_serv));
        chk({nm, ".dir"}, 8'(dir), 8'(m_dir));
        chk({nm, ".falha"}, 8'(falha), 8'(m_falha));
        chk({nm, ".cnt"}, atendidos, 8'(m_atend));
    endtask

    initial begin
        // inputs -> expected state after the following edge
        tbl[0] = mk(5'b01000, 0, 0, 3'd0, 5'b00000, 5'b01000, 0, 0, 8'd0);
        tbl[1] = mk(5'b00000, 0, 0, 3'd0, 5'b01000, 5'b01000, 1, 0, 8'd0);
        tbl[2] = mk(5'b00000, 0, 1, 3'd3, 5'b00000, 5'b00000, 0, 0, 8'd1);
        tbl[3] = mk(5'b00100, 0, 0, 3'd3, 5'b00000, 5'b00100, 0, 0, 8'd1);
        tbl[4] = mk(5'b00000, 1, 0, 3'd3, 5'b00000, 5'b00100, 0, 0, 8'd1);
        tbl[5] = mk(5'b00000, 1, 0, 3'd3, 5'b00000, 5'b00100, 0, 0, 8'd1);
        tbl[6] = mk(5'b00000, 0, 0, 3'd3, 5'b00100, 5'b00100, 1, 1, 8'd1);
        tbl[7] = mk(5'b00000, 0, 1, 3'd2, 5'b00000, 5'b00000, 0, 1, 8'd2);
        tbl[8] = mk(5'b00001, 0, 0, 3'd2, 5'b00000, 5'b00001, 0, 1, 8'd2);
        tbl[9] = mk(5'b00001, 0, 0, 3'd2, 5'b00001, 5'b00001, 1, 1, 8'd2);

        reset = 1'b1;
        #1;
        chk("rst.req", 8'(req), 8'd0);
        chk("rst.pend", 8'(pendentes), 8'd0);
        chk("rst.falha", 8'(falha), 8'd0);
        do_reset();

        for (int i = 0; i < 10; i++) begin
            botao = tbl[i].botao; busy = tbl[i].busy;
            door_open = tbl[i].door; andar_atual = tbl[i].andar;
            edge_();
            chk($sformatf("tbl%0d.req", i), 8'(req), 8'(tbl[i].e_req));
            chk($sformatf("tbl%0d.pend", i), 8'(pendentes), 8'(tbl[i].e_pend));
            chk($sformatf("tbl%0d.atd", i), 8'(atendendo), 8'(tbl[i].e_atd));
            chk($sformatf("tbl%0d.dir", i), 8'(dir), 8'(tbl[i].e_dir));
            chk($sformatf("tbl%0d.cnt", i), atendidos, tbl[i].e_cnt);
        end

        // asynchronous reset while serving floor 0, floor 1 button held through reset
        #2;
        botao = 5'b00010;
        reset = 1'b1;
        #1;
        chk("arst.req", 8'(req), 8'd0);
        chk("arst.pend", 8'(pendentes), 8'd0);
        chk("arst.alvo", 8'(alvo), 8'd0);
        chk("arst.atd", 8'(atendendo), 8'd0);
        chk("arst.dir", 8'(dir), 8'd0);
        chk("arst.falha", 8'(falha), 8'd0);
        chk("arst.cnt", atendidos, 8'd0);
        edge_();
        reset = 1'b0;
        edge_();
        chk("held.pend", 8'(pendentes), 8'b00010);

        // SCAN order 4, 1, 0 from floor 2 going up
        do_reset();
        botao = 5'b10011; andar_atual = 3'd2;
        edge_();
        chk("scan.pend", 8'(pendentes), 8'b10011);
        botao = '0;
        edge_();
        chk("scan.alvo0", 8'(alvo), 8'd4);
        chk("scan.dir0", 8'(dir), 8'd0);
        door_open = 1'b1; andar_atual = 3'd4;
        edge_();
        chk("scan.pend1", 8'(pendentes), 8'b00011);
        door_open = 1'b0;
        edge_();
        chk("scan.alvo1", 8'(alvo), 8'd1);
        chk("scan.dir1", 8'(dir), 8'd1);
        door_open = 1'b1; andar_atual = 3'd1;
        edge_();
        chk("scan.pend2", 8'(pendentes), 8'b00001);
        door_open = 1'b0;
        edge_();
        chk("scan.alvo2", 8'(alvo), 8'd0);
        chk("scan.req2", 8'(req), 8'b00001);
        door_open = 1'b1; andar_atual = 3'd0;
        edge_();
        chk("scan.pend3", 8'(pendentes), 8'd0);
        chk("scan.cnt", atendidos, 8'd3);

        // press of the target floor on the arrival edge is dropped
        do_reset();
        botao = 5'b01000;
        edge_();
        botao = '0;
        edge_();
        chk("same.req", 8'(req), 8'b01000);
        botao = 5'b01010; door_open = 1'b1; andar_atual = 3'd3;
        edge_();
        chk("same.pend", 8'(pendentes), 8'b00010);
        chk("same.req0", 8'(req), 8'd0);

        // timeout on floor 4, then calls latch but nothing dispatches
        do_reset();
        botao = 5'b10000;
        edge_();
        botao = '0;
        edge_();
        chk("tmo.req", 8'(req), 8'b10000);
        for (int k = 1; k <= TIMEOUT + 1; k++) begin
            edge_();
            if (k == TIMEOUT) begin
                chk("tmo.early", 8'(falha), 8'd0);
                chk("tmo.hold", 8'(req), 8'b10000);
            end
        end
        chk("tmo.falha", 8'(falha), 8'd1);
        chk("tmo.req0", 8'(req), 8'd0);
        chk("tmo.pend", 8'(pendentes), 8'd0);
        chk("tmo.atd", 8'(atendendo), 8'd0);
        botao = 5'b00001;
        edge_();
        botao = '0;
        chk("tmo.latch", 8'(pendentes), 8'b00001);
        for (int k = 0; k < 3; k++) edge_();
        chk("tmo.nodisp", 8'(req), 8'd0);
        chk("tmo.idle", 8'(atendendo), 8'd0);

        // randomized run against the model, periodic resets
        for (int c = 0; c < 3000; c++) begin
            if (c % 250 == 0) begin
                botao = 5'($urandom);
                reset = 1'b1;
                model_reset();
                #1;
                chk_model("rnd.rst");
                edge_();
                reset = 1'b0;
            end
            botao       = 5'($urandom & $urandom);
            busy        = ($urandom_range(0, 3) == 0);
            door_open   = ($urandom_range(0, 2) == 0);
            andar_atual = ($urandom_range(0, 1) == 1) ? 3'(m_alvo) : 3'($urandom_range(0, 4));
            model_step();
            edge_();
            chk_model("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
